// File: rtl/mic_capture_ctrl.sv
// ============================================================================
// Module  : mic_capture_ctrl
// Purpose : Stereo PDM mic sequencer: clock divider, warm-up, L/R word capture,
//           valid/ready delivery with sticky overflow.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mic_capture_ctrl #(
  parameter int SIZE       = 32,
  parameter int HALF_STD   = 12,
  parameter int HALF_ULTRA = 6,
  parameter int WARMUP     = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            ultra_req,
  input  logic            data_in,
  output logic            mic_clk_out,
  output logic [SIZE-1:0] out_left,
  output logic [SIZE-1:0] out_right,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            overflow,
  input  logic            ovf_clear,
  output logic            ultra_active,
  output logic            busy
);

  localparam int c_CW = $clog2(2 * (HALF_STD + HALF_ULTRA));
  localparam int c_BW = $clog2(SIZE + 1);
  localparam int c_WW = $clog2(WARMUP + 1);

  localparam logic [c_CW-1:0] c_HSTD    = c_CW'(HALF_STD);
  localparam logic [c_CW-1:0] c_HULTRA  = c_CW'(HALF_ULTRA);
  localparam logic [c_CW-1:0] c_GAP_M1  = c_CW'(2 * HALF_STD - 1);
  localparam logic [c_BW-1:0] c_SIZE_M1 = c_BW'(SIZE - 1);
  localparam logic [c_WW-1:0] c_WU_M1   = c_WW'(WARMUP - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_WARMUP = 2'd1;
  localparam logic [1:0] c_RUN    = 2'd2;
  localparam logic [1:0] c_GAP    = 2'd3;

  logic [1:0]      r_state;
  logic [c_CW-1:0] r_hcnt;
  logic [c_CW-1:0] r_gcnt;
  logic [c_BW-1:0] r_bcnt;
  logic [c_WW-1:0] r_wcnt;
  logic [SIZE-1:0] r_sh_l;
  logic [SIZE-1:0] r_sh_r;
  logic            r_load;

  logic [c_CW-1:0] w_half;
  logic            w_tick;
  logic            w_rise;
  logic            w_fall;
  logic            w_last_bit;
  logic            w_stop;

  always_comb begin
    w_half     = ultra_active ? c_HULTRA : c_HSTD;
    w_tick     = ((r_state == c_WARMUP) || (r_state == c_RUN)) &&
                 (r_hcnt == (w_half - c_CW'(1)));
    w_rise     = w_tick && !mic_clk_out;
    w_fall     = w_tick && mic_clk_out;
    w_last_bit = (r_state == c_RUN) && w_fall && (r_bcnt == c_SIZE_M1);
    w_stop     = !enable || (ultra_req != ultra_active);
  end

  assign busy = (r_state != c_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_IDLE;
      r_hcnt       <= '0;
      r_gcnt       <= '0;
      r_bcnt       <= '0;
      r_wcnt       <= '0;
      r_sh_l       <= '0;
      r_sh_r       <= '0;
      r_load       <= 1'b0;
      mic_clk_out  <= 1'b0;
      ultra_active <= 1'b0;
    end else begin
      r_load <= w_last_bit;
      if (w_tick) begin
        r_hcnt      <= '0;
        mic_clk_out <= ~mic_clk_out;
      end else if ((r_state == c_WARMUP) || (r_state == c_RUN)) begin
        r_hcnt <= r_hcnt + c_CW'(1);
      end
      case (r_state)
        c_IDLE: begin
          r_hcnt      <= '0;
          mic_clk_out <= 1'b0;
          if (enable) begin
            r_state      <= c_WARMUP;
            r_wcnt       <= '0;
            ultra_active <= ultra_req;
          end
        end
        c_WARMUP: begin
          // An abort while mic_clk is high waits for its falling tick so the
          // high phase is never shortened.
          if (w_stop && (!mic_clk_out || w_fall)) begin
            r_state     <= c_GAP;
            r_gcnt      <= '0;
            r_hcnt      <= '0;
            mic_clk_out <= 1'b0;
          end else if (w_fall) begin
            if (r_wcnt == c_WU_M1) begin
              r_state <= c_RUN;
              r_wcnt  <= '0;
              r_bcnt  <= '0;
            end else begin
              r_wcnt <= r_wcnt + c_WW'(1);
            end
          end
        end
        c_RUN: begin
          if (w_rise) r_sh_l <= {r_sh_l[SIZE-2:0], data_in};
          if (w_fall) begin
            r_sh_r <= {r_sh_r[SIZE-2:0], data_in};
            if (w_last_bit) begin
              r_bcnt <= '0;
              if (w_stop) begin
                r_state <= c_GAP;
                r_gcnt  <= '0;
              end
            end else begin
              r_bcnt <= r_bcnt + c_BW'(1);
            end
          end
        end
        default: begin
          r_hcnt      <= '0;
          mic_clk_out <= 1'b0;
          if (r_gcnt == c_GAP_M1) begin
            r_gcnt <= '0;
            if (enable) begin
              r_state      <= c_WARMUP;
              r_wcnt       <= '0;
              ultra_active <= ultra_req;
            end else begin
              r_state <= c_IDLE;
            end
          end else begin
            r_gcnt <= r_gcnt + c_CW'(1);
          end
        end
      endcase
    end
  end

  // A completed pair is loaded one cycle after its last right bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (r_load && (!out_valid || out_ready)) begin
        out_left  <= r_sh_l;
        out_right <= r_sh_r;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (ovf_clear) begin
        overflow <= 1'b0;
      end else if (r_load && out_valid && !out_ready) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mic_capture_ctrl.sv
// ============================================================================
// Module  : tb_mic_capture_ctrl
// Purpose : Self-checking bench for mic_capture_ctrl with an edge-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mic_capture_ctrl;
  localparam int SIZE = 32;
  localparam int HS   = 12;
  localparam int HU   = 6;
  localparam int WU   = 64;

  logic            clk = 1'b0;
  logic            rst_n, enable, ultra_req, data_in, out_ready, ovf_clear;
  logic            mic_clk_out, out_valid, overflow, ultra_active, busy;
  logic [SIZE-1:0] out_left, out_right;

  int total = 0;
  int bad   = 0;
  int dmode = 0;

  mic_capture_ctrl #(.SIZE(SIZE), .HALF_STD(HS), .HALF_ULTRA(HU), .WARMUP(WU)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ultra_req(ultra_req), .data_in(data_in),
    .mic_clk_out(mic_clk_out), .out_left(out_left), .out_right(out_right),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
    .ovf_clear(ovf_clear), .ultra_active(ultra_active), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: mic words are the data seen at mic_clk edges after each
  // restart, skipping the first WU periods; delivery is a one-slot holding buffer.
  bit              m_valid, m_ovf, m_pend;
  logic [SIZE-1:0] m_l, m_r, m_pl, m_pr, m_ol, m_or;
  int              m_p, m_nb, m_low, m_high, m_half;
  logic            m_prev;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      m_valid = 0; m_ovf = 0; m_pend = 0; m_ol = '0; m_or = '0;
      m_p = 0; m_nb = 0; m_low = 1000; m_high = 0; m_half = 0; m_prev = 1'b0;
    end else begin
      if (m_pend) begin
        if (!m_valid || out_ready) begin
          m_ol = m_pl; m_or = m_pr; m_valid = 1;
        end else if (!ovf_clear) begin
          m_ovf = 1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (ovf_clear) m_ovf = 0;
      m_pend = 0;
    end
    total++;
    if ({out_valid, overflow, out_left, out_right} !== {m_valid, m_ovf, m_ol, m_or}) begin
      bad++;
      $display("FAIL outputs t=%0t got v=%b o=%b l=%h r=%h want v=%b o=%b l=%h r=%h", $time,
               out_valid, overflow, out_left, out_right, m_valid, m_ovf, m_ol, m_or);
    end
    if (rst_n) begin
      if (mic_clk_out && !m_prev) begin
        if (m_low > HS) begin
          m_p = 0; m_nb = 0; m_half = 0;
        end else begin
          total++;
          if (m_low != m_half) begin
            bad++;
            $display("FAIL mic_low_time got=%0d want=%0d", m_low, m_half);
          end
        end
        if (m_p >= WU) m_l = {m_l[SIZE-2:0], data_in};
        m_high = 1;
      end else if (!mic_clk_out && m_prev) begin
        total++;
        if (m_half == 0) begin
          m_half = m_high;
          if (m_high != HS && m_high != HU) begin
            bad++;
            $display("FAIL mic_high_time got=%0d want=%0d or %0d", m_high, HS, HU);
          end
        end else if (m_high != m_half) begin
          bad++;
          $display("FAIL mic_high_time got=%0d want=%0d", m_high, m_half);
        end
        if (m_p >= WU) begin
          m_r = {m_r[SIZE-2:0], data_in};
          m_nb++;
          if (m_nb == SIZE) begin
            m_pend = 1; m_pl = m_l; m_pr = m_r; m_nb = 0;
          end
        end
        m_p++;
        m_low = 1;
      end else if (mic_clk_out) begin
        m_high++;
      end else if (m_low < 1000) begin
        m_low++;
      end
      m_prev = mic_clk_out;
    end
  end

  // Data source: random, constant 1, or 1 before each rise / 0 before each fall.
  initial begin
    forever begin
      @(posedge clk); #2;
      case (dmode)
        0:       data_in = 1'($urandom_range(0, 1));
        1:       data_in = 1'b1;
        default: data_in = ~mic_clk_out;
      endcase
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_valid(input int budget, output int n);
    int k;
    n = -1;
    for (k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        n = k;
        break;
      end
    end
    #1;
  endtask

  task automatic measure_period(output int per);
    int k, t0;
    logic pv;
    per = -1; t0 = -1; pv = mic_clk_out;
    for (k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (mic_clk_out && !pv) begin
        if (t0 < 0) t0 = k;
        else begin
          per = k - t0;
          break;
        end
      end
      pv = mic_clk_out;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; enable = 0; ultra_req = 0; out_ready = 0; ovf_clear = 0; data_in = 0;
    repeat (3) step();
    total++;
    if ({mic_clk_out, out_valid, overflow, ultra_active, busy} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {mic_clk_out, out_valid, overflow, ultra_active, busy});
    end
    total++;
    if ({out_left, out_right} !== '0) begin
      bad++; $display("FAIL reset_words got l=%h r=%h want 0", out_left, out_right);
    end
    rst_n = 1;
    step();
  endtask

  task automatic test_std_run();
    int n, per;
    dmode = 1; out_ready = 1; enable = 1;
    wait_valid(3000, n);
    total++;
    if (n < 2304 || n > 2306) begin
      bad++; $display("FAIL first_valid_latency got=%0d want=2304..2306", n);
    end
    total++;
    if (out_left !== '1 || out_right !== '1) begin
      bad++; $display("FAIL ones_word got l=%h r=%h want ffffffff", out_left, out_right);
    end
    total++;
    if (ultra_active !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL std_mode got ua=%b busy=%b want 0 1", ultra_active, busy);
    end
    measure_period(per);
    total++;
    if (per != 2 * HS) begin
      bad++; $display("FAIL std_period got=%0d want=%0d", per, 2 * HS);
    end
  endtask

  task automatic test_toggle();
    int n;
    dmode = 2;
    wait_valid(800, n);
    wait_valid(800, n);
    total++;
    if (n != 32 * 2 * HS) begin
      bad++; $display("FAIL pair_spacing got=%0d want=%0d", n, 32 * 2 * HS);
    end
    total++;
    if (out_left !== '1 || out_right !== '0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL toggle_word got l=%h r=%h o=%b want ffffffff 00000000 0",
               out_left, out_right, overflow);
    end
  endtask

  task automatic test_overflow();
    int n, k;
    logic [SIZE-1:0] hl, hr;
    dmode = 0; out_ready = 0;
    wait_valid(800, n);
    hl = out_left; hr = out_right;
    for (k = 0; k < 900 && overflow !== 1'b1; k++) step();
    total++;
    if (overflow !== 1'b1) begin
      bad++; $display("FAIL overflow_set got=%b want=1", overflow);
    end
    total++;
    if (out_valid !== 1'b1 || out_left !== hl || out_right !== hr) begin
      bad++;
      $display("FAIL held_pair got v=%b l=%h r=%h want 1 %h %h", out_valid, out_left, out_right, hl, hr);
    end
    ovf_clear = 1; step(); ovf_clear = 0;
    total++;
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL overflow_clear got=%b want=0", overflow);
    end
    out_ready = 1; step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL held_accept got v=%b want=0", out_valid);
    end
  endtask

  task automatic test_mode_switch();
    int n, k, per;
    repeat (200) step();
    ultra_req = 1;
    for (k = 0; k < 1000 && ultra_active !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    total++;
    if (ultra_active !== 1'b1) begin
      bad++; $display("FAIL ultra_active got=%b want=1", ultra_active);
    end
    wait_valid(1300, n);
    total++;
    if (n < 1150 || n > 1154) begin
      bad++; $display("FAIL ultra_latency got=%0d want=1150..1154", n);
    end
    measure_period(per);
    total++;
    if (per != 2 * HU) begin
      bad++; $display("FAIL ultra_period got=%0d want=%0d", per, 2 * HU);
    end
  endtask

  task automatic test_disable();
    int k;
    repeat (100) step();
    out_ready = 0; enable = 0;
    for (k = 0; k < 1000 && busy !== 1'b0; k++) step();
    total++;
    if (busy !== 1'b0 || mic_clk_out !== 1'b0) begin
      bad++; $display("FAIL stop_idle got busy=%b mic=%b want 0 0", busy, mic_clk_out);
    end
    repeat (5) step();
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL final_pair_pending got v=%b want=1", out_valid);
    end
    out_ready = 1; ovf_clear = 1; step(); ovf_clear = 0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL final_pair_accept got v=%b want=0", out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    enable = 1;
    wait_valid(1300, n);
    repeat (50) step();
    rst_n = 0;
    #1;
    total++;
    if ({mic_clk_out, out_valid, overflow, ultra_active, busy} !== 5'b0 ||
        {out_left, out_right} !== '0) begin
      bad++;
      $display("FAIL async_reset got mic=%b v=%b o=%b ua=%b busy=%b l=%h r=%h want all 0",
               mic_clk_out, out_valid, overflow, ultra_active, busy, out_left, out_right);
    end
    step();
    rst_n = 1;
    wait_valid(1300, n);
    total++;
    if (n < 1152 || n > 1154) begin
      bad++; $display("FAIL restart_latency got=%0d want=1152..1154", n);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clear = ($urandom_range(0, 15) == 0);
      step();
    end
    out_ready = 1; ovf_clear = 0;
    repeat (4) step();
  endtask

  initial begin
    test_reset();
    test_std_run();
    test_toggle();
    test_overflow();
    test_mode_switch();
    test_disable();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
